// File: rtl/mdu_arbiter_pkg.sv
// Shared types for the MDU arbiter: funct3 codes, FSM states,
// reuse key classes and the funct3-driven result select.
package mdu_arbiter_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_e;

    typedef enum logic [2:0] {
        KEY_MS,
        KEY_MSU,
        KEY_MU,
        KEY_DS,
        KEY_DU
    } key_e;

    // Ops sharing a key class produce identical MDU outputs for equal operands
    function automatic key_e key_class(input logic [2:0] f3);
        key_e k;
        case (f3)
            F3_MUL, F3_MULH: k = KEY_MS;
            F3_MULHSU:       k = KEY_MSU;
            F3_MULHU:        k = KEY_MU;
            F3_DIV, F3_REM:  k = KEY_DS;
            default:         k = KEY_DU;
        endcase
        return k;
    endfunction

    function automatic logic [XLEN-1:0] sel_result(
        input logic [2:0]        f3,
        input logic [2*XLEN-1:0] prod,
        input logic [XLEN-1:0]   quo,
        input logic [XLEN-1:0]   rem
    );
        logic [XLEN-1:0] r;
        case (f3)
            F3_MUL:                      r = prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: r = prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:             r = quo;
            default:                     r = rem;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mdu_rr_arbiter.sv
// Combinational round-robin grant: first requester at or
// after the pointer, searching cyclically.
module mdu_rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [1:0]         ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [1:0]         idx_o,
    output logic               any_o
);

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!any_o && req_i[j] &&
                    ((int'(ptr_i) + i) % NUM_REQ) == j) begin
                    any_o      = 1'b1;
                    grant_o[j] = 1'b1;
                    idx_o      = 2'(j);
                end
            end
        end
    end

endmodule

// File: rtl/mdu_arbiter.sv
// Round-robin share of one mdu_macro between NUM_REQ requesters.
// Optional MDU_ARB_REUSE_EN adds a one-entry result reuse buffer.
module mdu_arbiter
    import mdu_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [3*NUM_REQ-1:0]      req_funct3,
    input  logic [XLEN*NUM_REQ-1:0]   req_a,
    input  logic [XLEN*NUM_REQ-1:0]   req_b,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [XLEN-1:0]           rsp_data,
    output logic                      mdu_start,
    output logic                      mdu_ack,
    output logic [2:0]                mdu_funct3,
    output logic [XLEN-1:0]           mdu_a,
    output logic [XLEN-1:0]           mdu_b,
    input  logic                      mdu_busy,
    input  logic                      mdu_done,
    input  logic [2*XLEN-1:0]         mdu_product,
    input  logic [XLEN-1:0]           mdu_quotient,
    input  logic [XLEN-1:0]           mdu_remainder,
    output logic                      arb_busy
);

    state_e          state_q, state_d;
    logic [1:0]      rr_q, rr_d;
    logic [1:0]      owner_q, owner_d;
    logic [2:0]      f3_q, f3_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] data_q, data_d;

    logic [NUM_REQ-1:0] grant;
    logic [1:0]         gidx;
    logic               gany;
    logic [2:0]         g_f3;
    logic [XLEN-1:0]    g_a;
    logic [XLEN-1:0]    g_b;
    logic               rsp_ack;
    logic               hit;
    logic [XLEN-1:0]    hit_data;

    mdu_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req_i   (req_valid),
        .ptr_i   (rr_q),
        .grant_o (grant),
        .idx_o   (gidx),
        .any_o   (gany)
    );

    always_comb begin
        g_f3    = '0;
        g_a     = '0;
        g_b     = '0;
        rsp_ack = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gidx == 2'(i)) begin
                g_f3 = req_funct3[3*i +: 3];
                g_a  = req_a[XLEN*i +: XLEN];
                g_b  = req_b[XLEN*i +: XLEN];
            end
            if (owner_q == 2'(i)) begin
                rsp_ack = rsp_ready[i];
            end
        end
    end

`ifdef MDU_ARB_REUSE_EN
    logic              buf_v_q;
    logic [XLEN-1:0]   buf_a_q;
    logic [XLEN-1:0]   buf_b_q;
    key_e              buf_k_q;
    logic [2*XLEN-1:0] buf_p_q;
    logic [XLEN-1:0]   buf_quo_q;
    logic [XLEN-1:0]   buf_rem_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_v_q   <= 1'b0;
            buf_a_q   <= '0;
            buf_b_q   <= '0;
            buf_k_q   <= KEY_MS;
            buf_p_q   <= '0;
            buf_quo_q <= '0;
            buf_rem_q <= '0;
        end else if (state_q == ST_WAIT && mdu_done) begin
            buf_v_q   <= 1'b1;
            buf_a_q   <= a_q;
            buf_b_q   <= b_q;
            buf_k_q   <= key_class(f3_q);
            buf_p_q   <= mdu_product;
            buf_quo_q <= mdu_quotient;
            buf_rem_q <= mdu_remainder;
        end
    end

    assign hit = buf_v_q && buf_a_q == g_a && buf_b_q == g_b &&
                 buf_k_q == key_class(g_f3);
    assign hit_data = sel_result(g_f3, buf_p_q, buf_quo_q, buf_rem_q);
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        owner_d   = owner_q;
        f3_d      = f3_q;
        a_d       = a_q;
        b_d       = b_q;
        data_d    = data_q;
        req_ready = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (gany && !mdu_busy && !rst) begin
                    req_ready = grant;
                    owner_d   = gidx;
                    f3_d      = g_f3;
                    a_d       = g_a;
                    b_d       = g_b;
                    rr_d      = (gidx == 2'(NUM_REQ - 1)) ? 2'd0 : gidx + 2'd1;
                    if (hit) begin
                        data_d  = hit_data;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (mdu_done) begin
                    data_d  = sel_result(f3_q, mdu_product,
                                         mdu_quotient, mdu_remainder);
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ack) state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rr_q    <= '0;
            owner_q <= '0;
            f3_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            f3_q    <= f3_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = (state_q == ST_RESP) && (owner_q == 2'(i));
        end
    end

    assign mdu_start  = (state_q == ST_ISSUE);
    assign mdu_ack    = (state_q == ST_WAIT) && mdu_done;
    assign mdu_funct3 = f3_q;
    assign mdu_a      = a_q;
    assign mdu_b      = b_q;
    assign rsp_data   = data_q;
    assign arb_busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mdu_arbiter.sv
// Directed bench for mdu_arbiter with a small behavioural MDU
// (3-cycle latency, done held until ack).
module tb_mdu_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [5:0]  req_funct3 = '0;
    logic [63:0] req_a = '0;
    logic [63:0] req_b = '0;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = '0;
    logic [31:0] rsp_data;
    logic        mdu_start;
    logic        mdu_ack;
    logic [2:0]  mdu_funct3;
    logic [31:0] mdu_a;
    logic [31:0] mdu_b;
    logic        mdu_busy;
    logic        mdu_done;
    logic [63:0] mdu_product;
    logic [31:0] mdu_quotient;
    logic [31:0] mdu_remainder;
    logic        arb_busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mdu_arbiter #(.NUM_REQ(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_funct3    (req_funct3),
        .req_a         (req_a),
        .req_b         (req_b),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .mdu_start     (mdu_start),
        .mdu_ack       (mdu_ack),
        .mdu_funct3    (mdu_funct3),
        .mdu_a         (mdu_a),
        .mdu_b         (mdu_b),
        .mdu_busy      (mdu_busy),
        .mdu_done      (mdu_done),
        .mdu_product   (mdu_product),
        .mdu_quotient  (mdu_quotient),
        .mdu_remainder (mdu_remainder),
        .arb_busy      (arb_busy)
    );

    function automatic logic [63:0] f_prod(input logic [2:0] f3,
                                           input logic [31:0] a, b);
        logic [63:0] ea, eb;
        ea = (f3 == 3'b011) ? {32'b0, a} : {{32{a[31]}}, a};
        eb = (f3 == 3'b010 || f3 == 3'b011) ? {32'b0, b} : {{32{b[31]}}, b};
        return ea * eb;
    endfunction

    function automatic logic [31:0] f_quo(input logic [2:0] f3,
                                          input logic [31:0] a, b);
        if (b == 0) return 32'hFFFF_FFFF;
        if (f3[0]) return a / b;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return $signed(a) / $signed(b);
    endfunction

    function automatic logic [31:0] f_rem(input logic [2:0] f3,
                                          input logic [31:0] a, b);
        if (b == 0) return a;
        if (f3[0]) return a % b;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return $signed(a) % $signed(b);
    endfunction

    logic [2:0] m_cnt;
    always @(posedge clk) begin
        if (rst) begin
            mdu_busy      <= 1'b0;
            mdu_done      <= 1'b0;
            m_cnt         <= '0;
            mdu_product   <= '0;
            mdu_quotient  <= '0;
            mdu_remainder <= '0;
        end else begin
            if (mdu_start) begin
                mdu_busy      <= 1'b1;
                m_cnt         <= 3'd3;
                mdu_product   <= f_prod(mdu_funct3, mdu_a, mdu_b);
                mdu_quotient  <= f_quo(mdu_funct3, mdu_a, mdu_b);
                mdu_remainder <= f_rem(mdu_funct3, mdu_a, mdu_b);
            end else if (m_cnt != 0) begin
                m_cnt <= m_cnt - 3'd1;
                if (m_cnt == 3'd1) mdu_done <= 1'b1;
            end
            if (mdu_done && mdu_ack) begin
                mdu_done <= 1'b0;
                mdu_busy <= 1'b0;
            end
        end
    end

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || arb_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: ready=%b valid=%b busy=%b want 00 00 0",
                     req_ready, rsp_valid, arb_busy);
        end
        checks++;
        if (mdu_start !== 1'b0 || mdu_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_mdu: start=%b ack=%b want 0 0", mdu_start, mdu_ack);
        end
        checks++;
        if (mdu_funct3 !== 3'd0 || mdu_a !== 32'd0 || mdu_b !== 32'd0 ||
            rsp_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_data: f3=%h a=%h b=%h data=%h want zeros",
                     mdu_funct3, mdu_a, mdu_b, rsp_data);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_single(input int r, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp, input int exp_starts,
                               input string name);
        int starts, acks, gcyc;
        bit got;
        logic [1:0] oh;
        oh = 2'b01 << r;
        starts = 0;
        acks = 0;
        gcyc = -1;
        got = 0;
        @(posedge clk);
        #1;
        req_funct3[3*r +: 3] = f3;
        req_a[32*r +: 32] = a;
        req_b[32*r +: 32] = b;
        req_valid[r] = 1'b1;
        rsp_ready = oh;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (mdu_start) begin
                starts++;
                if (starts == 1) begin
                    checks++;
                    if (i != gcyc + 1) begin
                        errors++;
                        $display("FAIL %s start_lat: cycle %0d want %0d", name, i, gcyc + 1);
                    end
                end
            end
            if (mdu_ack) acks++;
            if (rsp_valid != 2'b00) begin
                got = 1;
                checks++;
                if (rsp_valid !== oh || rsp_data !== exp) begin
                    errors++;
                    $display("FAIL %s rsp: valid=%b data=%h want %b %h",
                             name, rsp_valid, rsp_data, oh, exp);
                end
                if (exp_starts == 0) begin
                    checks++;
                    if (i != gcyc + 1) begin
                        errors++;
                        $display("FAIL %s reuse_lat: cycle %0d want %0d", name, i, gcyc + 1);
                    end
                end
            end
            if (req_ready != 2'b00 && gcyc < 0) begin
                checks++;
                if (req_ready !== oh) begin
                    errors++;
                    $display("FAIL %s grant: ready=%b want %b", name, req_ready, oh);
                end
                gcyc = i;
                @(posedge clk);
                #1 req_valid[r] = 1'b0;
            end
        end
        if (!got) begin
            errors++;
            checks++;
            $display("FAIL %s timeout: no rsp_valid want one", name);
            req_valid = '0;
        end
        checks++;
        if (starts != exp_starts || acks != exp_starts) begin
            errors++;
            $display("FAIL %s pulses: starts=%0d acks=%0d want %0d %0d",
                     name, starts, acks, exp_starts, exp_starts);
        end
        @(posedge clk);
        #1;
        rsp_ready = '0;
        checks++;
        if (arb_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: arb_busy=%b want 0", name, arb_busy);
        end
    endtask

    task automatic test_alternate;
        int n0, n1, ng, nr;
        logic [31:0] expq[$];
        logic [1:0] ownq[$];
        logic [1:0] g;
        bit oh_ok;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        n0 = 0; n1 = 0; ng = 0; nr = 0; oh_ok = 1;
        req_funct3 = 6'b000_000;
        req_a = {32'd20, 32'd10};
        req_b = {32'd3, 32'd2};
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int i = 0; i < 200 && nr < 6; i++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00 && rsp_valid != 2'b01 && rsp_valid != 2'b10)
                oh_ok = 0;
            if (rsp_valid != 2'b00 && expq.size() > 0) begin
                checks++;
                if (rsp_valid !== ownq[0] || rsp_data !== expq[0]) begin
                    errors++;
                    $display("FAIL alt_rsp%0d: valid=%b data=%h want %b %h",
                             nr, rsp_valid, rsp_data, ownq[0], expq[0]);
                end
                void'(expq.pop_front());
                void'(ownq.pop_front());
                nr++;
            end
            if (req_ready != 2'b00) begin
                g = req_ready;
                checks++;
                if (g !== ((ng % 2 == 0) ? 2'b01 : 2'b10)) begin
                    errors++;
                    $display("FAIL alt_grant%0d: ready=%b want %b", ng, g,
                             (ng % 2 == 0) ? 2'b01 : 2'b10);
                end
                if (g == 2'b01) expq.push_back(req_a[31:0] * req_b[31:0]);
                else            expq.push_back(req_a[63:32] * req_b[63:32]);
                ownq.push_back(g);
                ng++;
                @(posedge clk);
                #1;
                if (g == 2'b01) begin
                    n0++;
                    req_a[31:0] = 32'(10 + n0);
                    if (n0 == 3) req_valid[0] = 1'b0;
                end else begin
                    n1++;
                    req_a[63:32] = 32'(20 + n1);
                    if (n1 == 3) req_valid[1] = 1'b0;
                end
            end
        end
        checks++;
        if (nr != 6) begin
            errors++;
            $display("FAIL alt_count: responses=%0d want 6", nr);
        end
        checks++;
        if (!oh_ok) begin
            errors++;
            $display("FAIL alt_onehot: rsp_valid=%b seen not one-hot want one-hot", rsp_valid);
        end
        req_valid = '0;
        @(posedge clk);
        #1 rsp_ready = '0;
    endtask

    task automatic test_backpressure;
        bit got;
        got = 0;
        @(posedge clk);
        #1;
        req_funct3[2:0] = 3'b000;
        req_a[31:0] = 32'd9;
        req_b[31:0] = 32'd9;
        req_valid = 2'b01;
        rsp_ready = 2'b00;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) got = 1;
            if (req_ready[0]) begin
                @(posedge clk);
                #1 req_valid[0] = 1'b0;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL bp_timeout: no rsp_valid want one");
        end
        @(posedge clk);
        #1;
        req_funct3[5:3] = 3'b000;
        req_a[63:32] = 32'd3;
        req_b[63:32] = 32'd4;
        req_valid[1] = 1'b1;
        rsp_ready = 2'b10;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 2'b01 || rsp_data !== 32'd81 ||
                mdu_start !== 1'b0 || req_ready !== 2'b00) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b data=%h start=%b ready=%b want 01 51 0 00",
                         i, rsp_valid, rsp_data, mdu_start, req_ready);
            end
        end
        @(posedge clk);
        #1 rsp_ready = 2'b11;
        @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 2'b10 || mdu_start !== 1'b0 || rsp_valid !== 2'b00) begin
            errors++;
            $display("FAIL bp_next_grant: ready=%b start=%b valid=%b want 10 0 00",
                     req_ready, mdu_start, rsp_valid);
        end
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        checks++;
        if (mdu_start !== 1'b1) begin
            errors++;
            $display("FAIL bp_start: start=%b want 1", mdu_start);
        end
        got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) begin
                got = 1;
                checks++;
                if (rsp_valid !== 2'b10 || rsp_data !== 32'd12) begin
                    errors++;
                    $display("FAIL bp_req1: valid=%b data=%h want 10 0000000c",
                             rsp_valid, rsp_data);
                end
            end
        end
        if (!got) begin
            errors++;
            checks++;
            $display("FAIL bp_req1_timeout: no rsp_valid want one");
        end
        @(posedge clk);
        #1 rsp_ready = '0;
    endtask

    task automatic test_mid_reset;
        bit started;
        started = 0;
        @(posedge clk);
        #1;
        req_funct3[2:0] = 3'b100;
        req_a[31:0] = 32'd100;
        req_b[31:0] = 32'd7;
        req_valid = 2'b01;
        rsp_ready = 2'b01;
        for (int i = 0; i < 30 && !started; i++) begin
            @(negedge clk);
            if (mdu_start) started = 1;
            if (req_ready[0]) begin
                @(posedge clk);
                #1 req_valid[0] = 1'b0;
            end
        end
        checks++;
        if (!started) begin
            errors++;
            $display("FAIL mr_start: no mdu_start want one");
        end
        @(posedge clk);
        #1;
        checks++;
        if (arb_busy !== 1'b1 || mdu_done !== 1'b0) begin
            errors++;
            $display("FAIL mr_wait: busy=%b done=%b want 1 0", arb_busy, mdu_done);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || mdu_start !== 1'b0 ||
            mdu_ack !== 1'b0 || mdu_funct3 !== 3'd0 || mdu_a !== 32'd0 ||
            mdu_b !== 32'd0 || rsp_data !== 32'd0 || arb_busy !== 1'b0) begin
            errors++;
            $display("FAIL mr_zero: rdy=%b v=%b st=%b ack=%b f3=%h a=%h b=%h d=%h busy=%b want all 0",
                     req_ready, rsp_valid, mdu_start, mdu_ack, mdu_funct3,
                     mdu_a, mdu_b, rsp_data, arb_busy);
        end
        rst = 1'b0;
        started = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00 || mdu_start) started = 1;
        end
        checks++;
        if (started) begin
            errors++;
            $display("FAIL mr_abandon: activity after reset want none");
        end
        rsp_ready = '0;
        test_single(0, 3'b100, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1, "div_neg");
    endtask

    initial begin
        test_reset();
        test_single(0, 3'b000, 32'd7, 32'd6, 32'd42, 1, "mul");
        test_single(1, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, "mulhu");
        test_single(1, 3'b101, 32'd100, 32'd7, 32'd14, 1, "divu");
`ifdef MDU_ARB_REUSE_EN
        test_single(1, 3'b111, 32'd100, 32'd7, 32'd2, 0, "remu");
`else
        test_single(1, 3'b111, 32'd100, 32'd7, 32'd2, 1, "remu");
`endif
        test_single(0, 3'b001, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1, "mulh");
        test_single(0, 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1, "mulhsu");
        test_single(1, 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "divu_zero");
        test_single(1, 3'b110, 32'd5, 32'd0, 32'd5, 1, "rem_zero");
        test_alternate();
        test_backpressure();
        test_mid_reset();
`ifdef MDU_ARB_REUSE_EN
        test_single(1, 3'b101, 32'd100, 32'd7, 32'd14, 1, "reuse_divu");
        test_single(1, 3'b111, 32'd100, 32'd7, 32'd2, 0, "reuse_remu");
        test_single(1, 3'b100, 32'd100, 32'd7, 32'd14, 1, "reuse_div_miss");
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mdu_arbiter.md
Name: mdu_arbiter

Overview:
Shares one mdu_macro instance between NUM_REQ requesters, e.g. the execute stage and a co-processor or debug port. Each requester uses a valid/ready command handshake and a valid/ready response handshake. The block arbitrates round-robin, latches operands, sequences the MDU start/done/ack handshake, and selects the 32-bit result from funct3. It sits between the core pipeline and mdu_macro in the core top level.

Parameters:
NUM_REQ, 2, number of requesters (legal range 2..4).
XLEN, 32, operand/result width; fixed at 32 and taken from the shared package.

Ports:
clk  in  1  core clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  NUM_REQ  per-requester command valid.
req_ready  out  NUM_REQ  per-requester command accept; one-hot or zero.
req_funct3  in  3*NUM_REQ  RV32M funct3, requester i at [3i+2:3i].
req_a  in  32*NUM_REQ  rs1 operand per requester.
req_b  in  32*NUM_REQ  rs2 operand per requester.
rsp_valid  out  NUM_REQ  one-hot response valid to the owning requester.
rsp_ready  in  NUM_REQ  per-requester response accept.
rsp_data  out  32  selected result, shared by all requesters.
mdu_start  out  1  one-cycle start pulse to the MDU.
mdu_ack  out  1  one-cycle result acknowledge to the MDU.
mdu_funct3  out  3  latched funct3.
mdu_a  out  32  latched operand a.
mdu_b  out  32  latched operand b.
mdu_busy  in  1  MDU busy.
mdu_done  in  1  MDU done; held high until ack.
mdu_product  in  64  MDU product.
mdu_quotient  in  32  MDU quotient.
mdu_remainder  in  32  MDU remainder.
arb_busy  out  1  high whenever the FSM state is not IDLE.

Behaviour:
- Reset (synchronous, rst=1): state=IDLE; rr_ptr=0; all req_ready/rsp_valid=0; mdu_start=mdu_ack=0; mdu_funct3/a/b=0; rsp_data=0; arb_busy=0. The same rst resets mdu_macro, so a reset mid-operation abandons the operation and emits no response.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is high and mdu_busy=0, grant the first valid requester at or after rr_ptr (cyclic search).
  - req_ready[g]=1 combinationally in that cycle. Latch funct3/a/b and owner g. Set rr_ptr=(g+1) mod NUM_REQ. Go to ISSUE.
  - If mdu_busy=1, grant nothing.
- ISSUE: mdu_start=1 for exactly this cycle; go to WAIT.
- WAIT: on mdu_done=1, register the selected result into rsp_data, pulse mdu_ack=1 in the same cycle, and go to RESP.
- Result select (funct3):
  - 000 -> product[31:0]
  - 001, 010, 011 -> product[63:32]
  - 100, 101 -> quotient
  - 110, 111 -> remainder
  - Divide-by-zero and overflow values are the MDU's outputs, passed through unmodified.
- RESP:
  - rsp_valid[owner]=1 and rsp_data are held stable until rsp_ready[owner]=1.
  - On that handshake, return to IDLE. A new grant is possible in the following cycle, not the same cycle.
  - rsp_ready from non-owners is ignored.
- Latency: command accepted at cycle T gives mdu_start at T+1; MDU done at D gives rsp_valid at D+1. Minimum issue-to-issue spacing is 4 cycles plus MDU latency.
- Simultaneous valids: only one grant per cycle. Losers keep req_valid asserted and are served in rotation, so no requester starves.
- Requester rules:
  - A requester must hold req_valid and its operands until req_ready.
  - Dropping req_valid before grant is legal and is treated as a withdrawal.
- Illegal funct3 does not exist; all 8 encodings are valid.

Optional Feature:
Macro MDU_ARB_REUSE_EN.
- When defined: a single-entry reuse buffer holds {valid, a, b, key, product, quotient, remainder} from the last MDU completion.
  - Key classes: {000,001}=MS, 010=MSU, 011=MU, {100,110}=DS, {101,111}=DU.
  - In IDLE, a granted request whose a, b and key class match a valid entry skips ISSUE/WAIT. It goes directly to RESP with data selected from the buffer, so rsp_valid appears at T+1 and mdu_start is never pulsed.
  - The buffer is updated on every WAIT->RESP transition and invalidated by rst.
- When undefined: the buffer logic is absent and every request goes through the MDU.

Decomposition:
- Package riscv_mdu_pkg (or additions to riscv_defines.vh): XLEN, funct3 constants (MUL..REMU), FSM state encoding, key-class encoding.
- One sub-module is natural: mdu_rr_arbiter, combinational first-at-or-after-pointer one-hot grant, parameterised by NUM_REQ.
- Result selection and the reuse buffer stay in mdu_arbiter.

Test Plan:
- Req0 MUL a=7 b=6 -> one mdu_start pulse, rsp_valid[0] with rsp_data=42, mdu_ack pulsed exactly once.
- Req1 MULHU a=b=0xFFFFFFFF -> rsp_data=0xFFFFFFFE. Req1 DIVU 100/7 -> 14. Req1 REMU 100/7 -> 2.
- Both requesters valid every cycle for 6 ops -> grants alternate 0,1,0,1,0,1; rsp_valid always one-hot.
- rsp_ready held low 5 cycles in RESP -> rsp_valid and rsp_data stable; no new mdu_start until the handshake completes.
- rst asserted in WAIT -> next cycle all outputs zero and state IDLE. A subsequent DIV -100/7 returns 0xFFFFFFF2 (-14).
- With MDU_ARB_REUSE_EN: DIVU 100/7 then REMU 100/7 -> second op returns 2 at T+1 with no mdu_start. DIV 100/7 after DIVU -> miss, MDU restarted.
